// File: rtl/func_sqrt_cbrt_if.sv
// Operand/request and status/result bundle for the sqrt(a + cbrt(b)) unit.
interface func_sqrt_cbrt_if;
  logic [7:0] a_bi;
  logic [7:0] b_bi;
  logic       start_i;
  logic [1:0] busy_o;
  logic [4:0] y_bo;

  modport master (
    output a_bi,
    output b_bi,
    output start_i,
    input  busy_o,
    input  y_bo
  );

  modport slave (
    input  a_bi,
    input  b_bi,
    input  start_i,
    output busy_o,
    output y_bo
  );
endinterface

// File: rtl/func_sqrt_cbrt.sv
// Iterative unit computing y = floor(sqrt(a + floor(cbrt(b)))).
// It runs 3 cube-root steps, then 5 restoring square-root steps. There is no divider.
module func_sqrt_cbrt (
  input  logic            clk_i,
  input  logic            rst_i,
  func_sqrt_cbrt_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CBRT = 2'b01,
    SQRT = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [8:0] x_q, x_d;
  logic [2:0] yc_q, yc_d;
  logic [2:0] s_q, s_d;
  logic [8:0] v_q, v_d;
  logic [8:0] r_q, r_d;
  logic [8:0] m_q, m_d;
  logic [4:0] y_q, y_d;

  logic [3:0]  yc2;
  logic [3:0]  yc_new;
  logic [13:0] t_base;
  logic [13:0] t;
  logic [8:0]  sq_b;
  logic [8:0]  r_nx;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    x_d     = x_q;
    yc_d    = yc_q;
    s_d     = s_q;
    v_d     = v_q;
    r_d     = r_q;
    m_d     = m_q;
    y_d     = y_q;

    // Trial subtrahend (3*yc*(yc+1)+1) << s. It is kept wide enough that the s=6 shift cannot wrap.
    yc2    = {yc_q, 1'b0};
    t_base = 14'd3 * {10'd0, yc2} * ({10'd0, yc2} + 14'd1) + 14'd1;
    t      = t_base << s_q;
    yc_new = yc2;
    sq_b   = r_q | m_q;
    r_nx   = r_q >> 1;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          a_d     = bus.a_bi;
          x_d     = {1'b0, bus.b_bi};
          yc_d    = 3'd0;
          s_d     = 3'd6;
          state_d = CBRT;
        end
      end
      CBRT: begin
        if ({5'd0, x_q} >= t) begin
          x_d    = x_q - t[8:0];
          yc_new = yc2 + 4'd1;
        end
        yc_d = yc_new[2:0];
        if (s_q == 3'd0) begin
          v_d     = {1'b0, a_q} + {5'd0, yc_new};
          r_d     = 9'd0;
          m_d     = 9'd256;
          s_d     = 3'd0;
          state_d = SQRT;
        end else begin
          s_d = s_q - 3'd3;
        end
      end
      SQRT: begin
        if (v_q >= sq_b) begin
          v_d  = v_q - sq_b;
          r_nx = (r_q >> 1) | m_q;
        end
        r_d = r_nx;
        m_d = m_q >> 2;
        if (m_q == 9'd1) begin
          y_d     = r_nx[4:0];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      x_q     <= '0;
      yc_q    <= '0;
      s_q     <= '0;
      v_q     <= '0;
      r_q     <= '0;
      m_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      x_q     <= x_d;
      yc_q    <= yc_d;
      s_q     <= s_d;
      v_q     <= v_d;
      r_q     <= r_d;
      m_q     <= m_d;
      y_q     <= y_d;
    end
  end

  assign bus.busy_o = state_q;
  assign bus.y_bo   = y_q;

endmodule

// File: tb/tb_func_sqrt_cbrt.sv
// Scoreboard bench for func_sqrt_cbrt: expected results are queued at start and checked on completion.
module tb_func_sqrt_cbrt;

  logic clk;
  logic rst_n;
  func_sqrt_cbrt_if bus ();

  func_sqrt_cbrt dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  int exp_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    nvec++;
    if (obs != exp) begin
      nmis++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: brute-force search, independent of the shift/subtract scheme
  function automatic int model(input int a, input int b);
    int c = 0;
    int v;
    int r = 0;
    while ((c + 1) * (c + 1) * (c + 1) <= b) c++;
    v = a + c;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy_o != 2'b00 && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit mid_start);
    int  n01 = 0;
    int  n10 = 0;
    int  cyc = 0;
    bit  order_ok = 1'b1;
    @(negedge clk);
    bus.a_bi    = a;
    bus.b_bi    = b;
    bus.start_i = 1'b1;
    exp_q.push_back(model(int'(a), int'(b)));
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.a_bi    = 8'($urandom);
    bus.b_bi    = 8'($urandom);
    while (bus.busy_o != 2'b00 && cyc < 20) begin
      if (bus.busy_o == 2'b01) begin
        n01++;
        if (n10 != 0) order_ok = 1'b0;
      end else if (bus.busy_o == 2'b10) begin
        n10++;
      end else begin
        order_ok = 1'b0;
      end
      bus.start_i = (mid_start && cyc == 2);
      cyc++;
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    check($sformatf("cbrt_cycles a=%0d b=%0d", a, b), n01, 3);
    check($sformatf("sqrt_cycles a=%0d b=%0d", a, b), n10, 5);
    check($sformatf("phase_order a=%0d b=%0d", a, b), int'(order_ok), 1);
    check($sformatf("y a=%0d b=%0d", a, b), int'(bus.y_bo), exp_q.pop_front());
  endtask

  initial begin
    int cyc;
    rst_n       = 1'b0;
    bus.a_bi    = 8'd0;
    bus.b_bi    = 8'd0;
    bus.start_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(bus.busy_o), 0);
    check("reset_y", int'(bus.y_bo), 0);
    rst_n = 1'b1;

    run_op(8'd0,   8'd0,   1'b0);
    run_op(8'd1,   8'd1,   1'b0);
    run_op(8'd12,  8'd60,  1'b1);
    run_op(8'd123, 8'd223, 1'b0);
    run_op(8'd255, 8'd255, 1'b1);

    // start held high: one IDLE cycle between back-to-back operations
    @(negedge clk);
    bus.a_bi    = 8'd12;
    bus.b_bi    = 8'd60;
    bus.start_i = 1'b1;
    exp_q.push_back(model(12, 60));
    @(negedge clk);
    wait_idle(cyc);
    check("hold_first_y", int'(bus.y_bo), exp_q.pop_front());
    exp_q.push_back(model(12, 60));
    @(negedge clk);
    check("hold_retrigger_busy", int'(bus.busy_o), 1);
    bus.start_i = 1'b0;
    wait_idle(cyc);
    check("hold_second_len", cyc, 8);
    check("hold_second_y", int'(bus.y_bo), exp_q.pop_front());

    run_op(8'd123, 8'd223, 1'b0);

    // asynchronous reset in the middle of the square-root phase
    @(negedge clk);
    bus.a_bi    = 8'd255;
    bus.b_bi    = 8'd255;
    bus.start_i = 1'b1;
    exp_q.push_back(model(255, 255));
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk);
    check("midop_busy_sqrt", int'(bus.busy_o), 2);
    rst_n = 1'b0;
    #1;
    check("midop_reset_busy", int'(bus.busy_o), 0);
    check("midop_reset_y", int'(bus.y_bo), 0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd255, 8'd255, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'(i % 2));
    end
    run_op(8'd0,   8'd255, 1'b0);
    run_op(8'd255, 8'd0,   1'b0);
    run_op(8'd0,   8'd7,   1'b0);
    run_op(8'd0,   8'd8,   1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
